// File: rtl/arf_sched_ctrl.sv
// ARF filter evaluator: 28-op dataflow graph time-shared over one pipelined multiplier
// and one adder, sequenced by fixed in-order issue lists and an operand scoreboard.
module arf_sched_ctrl #(
  parameter int W       = 16,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_valid,
  input  logic [4:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  // Entry = {op id, src a, src b}; src[5]=1 selects an external operand, else an op result.
  function automatic logic [16:0] mul_entry(input logic [4:0] idx);
    logic [16:0] e;
    e = 17'd0;
    if (idx < 5'd8) begin
      e = {idx + 5'd1, 1'b1, idx[3:0], 1'b0, 1'b1, idx[3:0], 1'b1};
    end else begin
      case (idx)
        5'd8:    e = {5'd15, 1'b0, 5'd13, 1'b1, 5'd18};
        5'd9:    e = {5'd16, 1'b0, 5'd14, 1'b1, 5'd19};
        5'd10:   e = {5'd17, 1'b0, 5'd13, 1'b1, 5'd20};
        5'd11:   e = {5'd18, 1'b0, 5'd14, 1'b1, 5'd21};
        5'd12:   e = {5'd21, 1'b0, 5'd19, 1'b1, 5'd22};
        5'd13:   e = {5'd22, 1'b0, 5'd20, 1'b1, 5'd23};
        5'd14:   e = {5'd23, 1'b0, 5'd19, 1'b1, 5'd24};
        5'd15:   e = {5'd24, 1'b0, 5'd20, 1'b1, 5'd25};
        default: e = 17'd0;
      endcase
    end
    return e;
  endfunction

  function automatic logic [16:0] add_entry(input logic [3:0] idx);
    logic [16:0] e;
    case (idx)
      4'd0:    e = {5'd9,  1'b0, 5'd1,  1'b0, 5'd2};
      4'd1:    e = {5'd10, 1'b0, 5'd3,  1'b0, 5'd4};
      4'd2:    e = {5'd11, 1'b0, 5'd5,  1'b0, 5'd6};
      4'd3:    e = {5'd12, 1'b0, 5'd7,  1'b0, 5'd8};
      4'd4:    e = {5'd13, 1'b0, 5'd10, 1'b1, 5'd16};
      4'd5:    e = {5'd14, 1'b0, 5'd11, 1'b1, 5'd17};
      4'd6:    e = {5'd19, 1'b0, 5'd15, 1'b0, 5'd16};
      4'd7:    e = {5'd20, 1'b0, 5'd17, 1'b0, 5'd18};
      4'd8:    e = {5'd25, 1'b0, 5'd21, 1'b0, 5'd22};
      4'd9:    e = {5'd26, 1'b0, 5'd23, 1'b0, 5'd24};
      4'd10:   e = {5'd27, 1'b0, 5'd9,  1'b0, 5'd25};
      4'd11:   e = {5'd28, 1'b0, 5'd12, 1'b0, 5'd26};
      default: e = 17'd0;
    endcase
    return e;
  endfunction

  state_t         state_q, state_d;
  logic [4:0]     mul_head_q, mul_head_d;
  logic [3:0]     add_head_q, add_head_d;
  logic [31:0]    rdy_q, rdy_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [W-1:0]   y0_q, y0_d, y1_q, y1_d;
  logic [W-1:0]   ext_mem [0:31];
  logic [W-1:0]   rf_mem  [0:31];

  logic [16:0]    mul_e_s, add_e_s;
  logic [4:0]     mul_op_s, add_op_s;
  logic [W-1:0]   mul_a_s, mul_b_s, add_a_s, add_b_s, mul_prod_s, add_sum_s;
  logic           mul_issue_s, add_issue_s;
  logic           wb_v_s;
  logic [4:0]     wb_id_s;
  logic [W-1:0]   wb_prod_s;

  // Operand fetch and issue decision for both shared units.
  always_comb begin
    mul_e_s     = mul_entry(mul_head_q);
    add_e_s     = add_entry(add_head_q);
    mul_op_s    = mul_e_s[16:12];
    add_op_s    = add_e_s[16:12];
    mul_a_s     = mul_e_s[11] ? ext_mem[mul_e_s[10:6]] : rf_mem[mul_e_s[10:6]];
    mul_b_s     = mul_e_s[5]  ? ext_mem[mul_e_s[4:0]]  : rf_mem[mul_e_s[4:0]];
    add_a_s     = add_e_s[11] ? ext_mem[add_e_s[10:6]] : rf_mem[add_e_s[10:6]];
    add_b_s     = add_e_s[5]  ? ext_mem[add_e_s[4:0]]  : rf_mem[add_e_s[4:0]];
    mul_prod_s  = mul_a_s * mul_b_s;
    add_sum_s   = add_a_s + add_b_s;
    mul_issue_s = (state_q == S_RUN) && (mul_head_q < 5'd16)
                  && (mul_e_s[11] || rdy_q[mul_e_s[10:6]])
                  && (mul_e_s[5]  || rdy_q[mul_e_s[4:0]]);
    add_issue_s = (state_q == S_RUN) && (add_head_q < 4'd12)
                  && (add_e_s[11] || rdy_q[add_e_s[10:6]])
                  && (add_e_s[5]  || rdy_q[add_e_s[4:0]]);
  end

  // Product reaches the result file at the end of cycle t+MUL_LAT-1 so it is usable at t+MUL_LAT.
  if (MUL_LAT == 1) begin : g_lat1
    assign wb_v_s    = mul_issue_s;
    assign wb_id_s   = mul_op_s;
    assign wb_prod_s = mul_prod_s;
  end else begin : g_latn
    logic [MUL_LAT-2:0] pv_q, pv_d;
    logic [4:0]         pid_q [0:MUL_LAT-2];
    logic [4:0]         pid_d [0:MUL_LAT-2];
    logic [W-1:0]       pp_q  [0:MUL_LAT-2];
    logic [W-1:0]       pp_d  [0:MUL_LAT-2];

    always_comb begin
      pv_d[0]  = mul_issue_s;
      pid_d[0] = mul_op_s;
      pp_d[0]  = mul_prod_s;
      for (int k = 1; k <= MUL_LAT - 2; k++) begin
        pv_d[k]  = pv_q[k-1];
        pid_d[k] = pid_q[k-1];
        pp_d[k]  = pp_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
        for (int k = 0; k <= MUL_LAT - 2; k++) begin
          pid_q[k] <= 5'd0;
          pp_q[k]  <= '0;
        end
      end else begin
        pv_q <= pv_d;
        for (int k = 0; k <= MUL_LAT - 2; k++) begin
          pid_q[k] <= pid_d[k];
          pp_q[k]  <= pp_d[k];
        end
      end
    end

    assign wb_v_s    = pv_q[MUL_LAT-2];
    assign wb_id_s   = pid_q[MUL_LAT-2];
    assign wb_prod_s = pp_q[MUL_LAT-2];
  end

  // Sequencing: list heads, scoreboard, FSM and captured outputs.
  always_comb begin
    state_d    = state_q;
    mul_head_d = mul_head_q;
    add_head_d = add_head_q;
    rdy_d      = rdy_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          mul_head_d = 5'd0;
          add_head_d = 4'd0;
          rdy_d      = 32'd0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_RUN: begin
        if (mul_issue_s) begin
          mul_head_d = mul_head_q + 5'd1;
        end else begin
          mul_head_d = mul_head_q;
        end
        if (wb_v_s) begin
          rdy_d[wb_id_s] = 1'b1;
        end else begin
          rdy_d[0] = rdy_q[0];
        end
        if (add_issue_s) begin
          add_head_d        = add_head_q + 4'd1;
          rdy_d[add_op_s]   = 1'b1;
          if (add_head_q == 4'd11) begin
            state_d = S_DONE;
            y0_d    = rf_mem[5'd27];
            y1_d    = add_sum_s;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          add_head_d = add_head_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mul_head_q <= 5'd0;
      add_head_q <= 4'd0;
      rdy_q      <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      y0_q       <= '0;
      y1_q       <= '0;
    end else begin
      state_q    <= state_d;
      mul_head_q <= mul_head_d;
      add_head_q <= add_head_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
    end
  end

  // Operand store and intermediate results are plain storage without reset.
  always_ff @(posedge clk) begin
    if (ld_valid && (state_q == S_IDLE) && (ld_addr < 5'd26)) begin
      ext_mem[ld_addr] <= ld_data;
    end
    if (add_issue_s) begin
      rf_mem[add_op_s] <= add_sum_s;
    end
    if (wb_v_s) begin
      rf_mem[wb_id_s] <= wb_prod_s;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y0   = y0_q;
  assign y1   = y1_q;

endmodule
